tpu_exec_sequencer: RTL and testbench

Parametrised successor to the single-shot exec decoder. Accepts a stream of decoded instructions over a valid/ready handshake and sequences each one over multiple cycles. For MATMUL it issues the systolic-array start and streams unified-buffer (UB) row addresses. For RD_WEIGHT it moves UB words into the weight FIFO under full backpressure. It sits between the instruction fetch/decode stage and the systolic array / UB / weight FIFO.

---
 rtl/tpu_isa_pkg.sv | 20 ++
 rtl/tpu_addr_counter.sv | 31 +++
 rtl/tpu_exec_sequencer.sv | 149 ++++++++++++++
 tb/tb_tpu_exec_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// rtl/tpu_isa_pkg.sv - ISA opcodes, sequencer state encoding and default widths
package tpu_isa_pkg;
  localparam int DEF_OPCODE_W = 6;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_ICNT_W   = 16;

  localparam int OP_NOP       = 'h00;
  localparam int OP_MATMUL    = 'h01;
  localparam int OP_RD_WEIGHT = 'h02;
  localparam int OP_SYNC      = 'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MM_STREAM,
    S_MM_WAIT,
    S_WT_LOAD,
    S_SYNC_WAIT
  } state_t;
endpackage

// File: rtl/tpu_addr_counter.sv
// rtl/tpu_addr_counter.sv - loadable UB address / remaining-count pair
module tpu_addr_counter #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  cnt,
  output logic              tc
);
  // cnt holds the words still to issue after the current one; tc marks the final word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= load_cnt;
    end else if (en) begin
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/tpu_exec_sequencer.sv
// rtl/tpu_exec_sequencer.sv - multi-cycle instruction sequencer for matmul, weight load and sync
module tpu_exec_sequencer
  import tpu_isa_pkg::*;
#(
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ICNT_W   = DEF_ICNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic [ADDR_W-1:0]   instr_arg1,
  input  logic [CNT_W-1:0]    instr_arg3,
  output logic                sys_start,
  output logic [CNT_W-1:0]    sys_rows,
  input  logic                sys_done,
  input  logic                sys_busy,
  output logic                ub_rd_en,
  output logic [ADDR_W-1:0]   ub_rd_addr,
  input  logic                wt_fifo_full,
  output logic                wt_fifo_wr,
  output logic                busy,
  output logic                err_illegal,
  output logic [ICNT_W-1:0]   instr_count
);
  localparam logic [OPCODE_W-1:0] NOP       = OPCODE_W'(OP_NOP);
  localparam logic [OPCODE_W-1:0] MATMUL    = OPCODE_W'(OP_MATMUL);
  localparam logic [OPCODE_W-1:0] RD_WEIGHT = OPCODE_W'(OP_RD_WEIGHT);
  localparam logic [OPCODE_W-1:0] SYNC      = OPCODE_W'(OP_SYNC);

  state_t            state;
  logic              done_seen;
  logic              accept, cnt_zero, is_mm, is_wt, is_sync, op_legal;
  logic              ctr_load, ctr_en, ctr_tc;
  logic [ADDR_W-1:0] ctr_load_addr, ctr_addr;
  logic [CNT_W-1:0]  ctr_cnt;

  assign accept   = instr_valid & instr_ready;
  assign cnt_zero = (instr_arg3 == '0);
  assign is_mm    = accept && (instr_opcode == MATMUL) && !cnt_zero;
  assign is_wt    = accept && (instr_opcode == RD_WEIGHT) && !cnt_zero;
  assign is_sync  = accept && (instr_opcode == SYNC);
  assign op_legal = instr_opcode inside {NOP, MATMUL, RD_WEIGHT, SYNC};

  // Matmul issues its first row straight from the accept, so the counter starts one word ahead
  assign ctr_load      = is_mm | is_wt;
  assign ctr_load_addr = is_mm ? instr_arg1 + ADDR_W'(1) : instr_arg1;
  assign ctr_en        = !ctr_tc && ((state == S_MM_STREAM) ||
                                     (state == S_WT_LOAD && !wt_fifo_full));

  tpu_addr_counter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (ctr_load),
    .load_addr (ctr_load_addr),
    .load_cnt  (instr_arg3 - CNT_W'(1)),
    .en        (ctr_en),
    .addr      (ctr_addr),
    .cnt       (ctr_cnt),
    .tc        (ctr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      done_seen   <= 1'b0;
      instr_ready <= 1'b0;
      sys_start   <= 1'b0;
      sys_rows    <= '0;
      ub_rd_en    <= 1'b0;
      ub_rd_addr  <= '0;
      wt_fifo_wr  <= 1'b0;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
      instr_count <= '0;
    end else begin
      sys_start  <= 1'b0;
      sys_rows   <= '0;
      ub_rd_en   <= 1'b0;
      wt_fifo_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          done_seen   <= 1'b0;
          if (is_mm) begin
            state       <= S_MM_STREAM;
            busy        <= 1'b1;
            instr_ready <= 1'b0;
            sys_start   <= 1'b1;
            sys_rows    <= instr_arg3;
            ub_rd_en    <= 1'b1;
            ub_rd_addr  <= instr_arg1;
          end else if (is_wt || is_sync) begin
            state       <= is_wt ? S_WT_LOAD : S_SYNC_WAIT;
            busy        <= 1'b1;
            instr_ready <= 1'b0;
          end else if (accept) begin
            // NOP, illegal opcodes and zero-length transfers retire on accept
            instr_count <= instr_count + ICNT_W'(1);
            if (!op_legal) err_illegal <= 1'b1;
          end
        end
        S_MM_STREAM: begin
          if (sys_done) done_seen <= 1'b1;
          if (ctr_tc) begin
            state <= S_MM_WAIT;
          end else begin
            ub_rd_en   <= 1'b1;
            ub_rd_addr <= ctr_addr;
          end
        end
        S_MM_WAIT: begin
          if (sys_done || done_seen) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
            instr_count <= instr_count + ICNT_W'(1);
          end
        end
        S_WT_LOAD: begin
          if (!wt_fifo_full) begin
            ub_rd_en   <= 1'b1;
            wt_fifo_wr <= 1'b1;
            ub_rd_addr <= ctr_addr;
            if (ctr_tc) begin
              state       <= S_IDLE;
              busy        <= 1'b0;
              instr_ready <= 1'b1;
              instr_count <= instr_count + ICNT_W'(1);
            end
          end
        end
        S_SYNC_WAIT: begin
          if (!sys_busy) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
            instr_count <= instr_count + ICNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_exec_sequencer.sv
// tb/tb_tpu_exec_sequencer.sv - randomized self-checking bench for tpu_exec_sequencer
module tb_tpu_exec_sequencer;
  import tpu_isa_pkg::*;

  localparam int OPCODE_W = 6;
  localparam int ADDR_W   = 8;
  localparam int CNT_W    = 8;
  localparam int ICNT_W   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] instr_opcode;
  logic [ADDR_W-1:0]   instr_arg1;
  logic [CNT_W-1:0]    instr_arg3;
  logic                sys_start;
  logic [CNT_W-1:0]    sys_rows;
  logic                sys_done;
  logic                sys_busy;
  logic                ub_rd_en;
  logic [ADDR_W-1:0]   ub_rd_addr;
  logic                wt_fifo_full;
  logic                wt_fifo_wr;
  logic                busy;
  logic                err_illegal;
  logic [ICNT_W-1:0]   instr_count;

  tpu_exec_sequencer #(
    .OPCODE_W(OPCODE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ICNT_W(ICNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_arg1(instr_arg1), .instr_arg3(instr_arg3),
    .sys_start(sys_start), .sys_rows(sys_rows), .sys_done(sys_done), .sys_busy(sys_busy),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .wt_fifo_full(wt_fifo_full), .wt_fifo_wr(wt_fifo_wr),
    .busy(busy), .err_illegal(err_illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [ICNT_W-1:0] exp_count;
  logic              exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, instr_ready, sys_start, ub_rd_en, wt_fifo_wr, busy, err_illegal}, 0);
    check({tag, "_data"}, {16'd0, sys_rows, ub_rd_addr}, 0);
    check({tag, "_count"}, instr_count, 0);
  endtask

  task automatic check_retired(input string tag);
    check({tag, "_ready"}, instr_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, instr_count, exp_count);
    check({tag, "_err"}, err_illegal, exp_err);
  endtask

  // Drive one instruction at a negedge; returns at the next negedge (first cycle after accept)
  task automatic issue(input logic [OPCODE_W-1:0] op, input logic [ADDR_W-1:0] a1,
                       input logic [CNT_W-1:0] a3);
    check("issue_ready", instr_ready, 1);
    instr_opcode = op;
    instr_arg1   = a1;
    instr_arg3   = a3;
    instr_valid  = 1'b1;
    step();
    instr_valid  = 1'b0;
  endtask

  task automatic run_retire(input logic [OPCODE_W-1:0] op, input logic [ADDR_W-1:0] a1,
                            input logic [CNT_W-1:0] a3);
    issue(op, a1, a3);
    exp_count++;
    if (op > 3) exp_err = 1'b1;
    check("ret_start", sys_start, 0);
    check("ret_rd_en", ub_rd_en, 0);
    check("ret_wr", wt_fifo_wr, 0);
    check_retired("ret");
  endtask

  // edone: 0 = sys_done arrives in MM_WAIT, k = pulsed during streamed row k
  task automatic run_mm(input logic [ADDR_W-1:0] a1, input logic [CNT_W-1:0] a3, input int edone);
    logic [ADDR_W-1:0] ea;
    int d;
    issue(OPCODE_W'(OP_MATMUL), a1, a3);
    for (int k = 1; k <= int'(a3); k++) begin
      if (k > 1) step();
      sys_done = 1'b0;
      ea = a1 + ADDR_W'(k - 1);
      check("mm_rd_en", ub_rd_en, 1);
      check("mm_addr", ub_rd_addr, ea);
      check("mm_start", sys_start, (k == 1));
      if (k == 1) check("mm_rows", sys_rows, a3);
      check("mm_ready", instr_ready, 0);
      check("mm_busy", busy, 1);
      if (k == edone) sys_done = 1'b1;
    end
    step();
    sys_done = 1'b0;
    check("mm_wait_rd_en", ub_rd_en, 0);
    check("mm_wait_start", sys_start, 0);
    check("mm_wait_ready", instr_ready, 0);
    if (edone == 0) begin
      d = $urandom_range(0, 3);
      repeat (d) begin
        step();
        check("mm_wait_hold", instr_ready, 0);
      end
      sys_done = 1'b1;
    end
    step();
    sys_done = 1'b0;
    exp_count++;
    check_retired("mm_done");
  endtask

  task automatic run_wt(input logic [ADDR_W-1:0] a1, input logic [CNT_W-1:0] a3,
                        input logic [31:0] mask, input logic rnd);
    logic [ADDR_W-1:0] exp_addr;
    int   rem;
    logic prev_full;
    logic done;
    exp_addr  = a1;
    rem       = int'(a3);
    prev_full = 1'b1;
    done      = 1'b0;
    issue(OPCODE_W'(OP_RD_WEIGHT), a1, a3);
    for (int j = 1; j <= int'(a3) + 40 && !done; j++) begin
      if (j > 1) step();
      if (!prev_full) begin
        check("wt_wr", wt_fifo_wr, 1);
        check("wt_rd_en", ub_rd_en, 1);
        check("wt_addr", ub_rd_addr, exp_addr);
        exp_addr++;
        rem--;
      end else begin
        check("wt_no_wr", wt_fifo_wr, 0);
        check("wt_no_rd", ub_rd_en, 0);
      end
      if (rem == 0) begin
        done = 1'b1;
        exp_count++;
        check_retired("wt_done");
      end else begin
        check("wt_ready", instr_ready, 0);
      end
      if (rnd) wt_fifo_full = (j < int'(a3) + 20) && ($urandom_range(0, 2) == 0);
      else     wt_fifo_full = (j < 32) ? mask[j] : 1'b0;
      prev_full = wt_fifo_full;
    end
    wt_fifo_full = 1'b0;
    check("wt_finished", done, 1);
    step();
    check("wt_after_wr", wt_fifo_wr, 0);
  endtask

  task automatic run_sync(input int b);
    int n;
    n = (b > 1) ? b : 1;
    sys_busy = (b > 0);
    issue(OPCODE_W'(OP_SYNC), ADDR_W'($urandom), CNT_W'($urandom));
    for (int j = 1; j <= n; j++) begin
      if (j > 1) step();
      check("sync_ready", instr_ready, 0);
      check("sync_busy", busy, 1);
      sys_busy = (j < b);
    end
    step();
    exp_count++;
    check_retired("sync_done");
  endtask

  task automatic run_reset_mid();
    issue(OPCODE_W'(OP_MATMUL), 8'h40, 8'd9);
    step();
    step();
    check("rm_row3_addr", ub_rd_addr, 8'h42);
    #2 rst = 1'b1;
    #1 check_zero("rm_async");
    step();
    check("rm_rd_en_a", ub_rd_en, 0);
    step();
    check("rm_rd_en_b", ub_rd_en, 0);
    rst = 1'b0;
    exp_count = '0;
    exp_err   = 1'b0;
    step();
    check("rm_rd_en_c", ub_rd_en, 0);
    check("rm_start", sys_start, 0);
    check_retired("rm_release");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    logic [CNT_W-1:0] a3;
    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_arg1   = '0;
    instr_arg3   = '0;
    sys_done     = 1'b0;
    sys_busy     = 1'b0;
    wt_fifo_full = 1'b0;
    exp_count    = '0;
    exp_err      = 1'b0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    check_retired("reset_release");

    run_mm(8'h10, 8'd9, 0);
    run_mm(8'hFE, 8'd4, 2);
    run_wt(8'h20, 8'd5, 32'h0000_001C, 1'b0);
    run_retire(6'h3F, 8'h00, 8'h00);
    run_retire(OPCODE_W'(OP_NOP), 8'h00, 8'h00);
    run_sync(0);
    run_sync(3);
    run_retire(OPCODE_W'(OP_MATMUL), 8'h33, 8'd0);
    run_retire(OPCODE_W'(OP_RD_WEIGHT), 8'h33, 8'd0);
    run_reset_mid();
    run_mm(8'h80, 8'd3, 0);

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 5);
      a3 = CNT_W'($urandom_range(0, 12));
      case (r)
        0: run_retire(OPCODE_W'(OP_NOP), ADDR_W'($urandom), CNT_W'($urandom));
        1: run_retire(OPCODE_W'($urandom_range(4, 63)), ADDR_W'($urandom), CNT_W'($urandom));
        2, 5: begin
          if (a3 == 0) run_retire(OPCODE_W'(OP_MATMUL), ADDR_W'($urandom), a3);
          else         run_mm(ADDR_W'($urandom), a3, $urandom_range(0, int'(a3)));
        end
        3: begin
          if (a3 == 0) run_retire(OPCODE_W'(OP_RD_WEIGHT), ADDR_W'($urandom), a3);
          else         run_wt(ADDR_W'($urandom), a3, 32'h0, 1'b1);
        end
        default: run_sync($urandom_range(0, 3));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
